// File: rtl/debug_cmd_decoder.sv
// ASCII-hex debug command line decoder: "Waadd\n" writes, "Raa\n" reads, CR ignored.
// Optional inter-byte timeout abort, compiled in when DEBUG_CMD_TIMEOUT_EN is defined.
module debug_cmd_decoder #(
    parameter int                             TIMEOUT_TICKS_WIDTH = 24,
    parameter logic [TIMEOUT_TICKS_WIDTH-1:0] TIMEOUT_TICKS       = 24'd2200000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_wr,
    output logic       cmd_rd,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       cmd_error,
    output logic [7:0] status,
    output logic       busy
);

    // state   | meaning
    // IDLE    | waiting for 'W'/'R' or an empty line
    // ADDR_HI | expecting high address nibble
    // ADDR_LO | expecting low address nibble
    // DATA_HI | expecting high data nibble (write only)
    // DATA_LO | expecting low data nibble (write only)
    // TERM    | expecting the terminating LF
    // DRAIN   | discarding a rejected line up to its LF
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_HI = 3'd1;
    localparam logic [2:0] ADDR_LO = 3'd2;
    localparam logic [2:0] DATA_HI = 3'd3;
    localparam logic [2:0] DATA_LO = 3'd4;
    localparam logic [2:0] TERM    = 3'd5;
    localparam logic [2:0] DRAIN   = 3'd6;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [2:0] state_q, state_d;
    logic       is_write_q, is_write_d;
    logic [7:0] addr_sh_q, addr_sh_d;
    logic [7:0] data_sh_q, data_sh_d;
    logic [7:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] cmd_data_q, cmd_data_d;
    logic       cmd_wr_q, cmd_wr_d;
    logic       cmd_rd_q, cmd_rd_d;
    logic       cmd_error_q, cmd_error_d;
    logic [3:0] acc_cnt_q, acc_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       tmo_fire;

    logic       hex_ok;
    logic [3:0] hex_nib;
    logic       is_cmd_w;
    logic       is_cmd_r;

    always_comb begin
        hex_ok  = 1'b1;
        hex_nib = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            hex_nib = rx_data[3:0] + 4'd9;
        end else begin
            hex_ok = 1'b0;
        end
        is_cmd_w = (rx_data == 8'h57) || (rx_data == 8'h77);
        is_cmd_r = (rx_data == 8'h52) || (rx_data == 8'h72);
    end

`ifdef DEBUG_CMD_TIMEOUT_EN
    logic [TIMEOUT_TICKS_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_fire  = (state_q != IDLE) && !rx_valid && (tmo_cnt_q == TIMEOUT_TICKS);
        tmo_cnt_d = tmo_cnt_q + TIMEOUT_TICKS_WIDTH'(1);
        if (state_q == IDLE || rx_valid || tmo_fire) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_fire = 1'b0;

    // Timeout parameters only matter when the abort path is compiled in.
    if (TIMEOUT_TICKS_WIDTH < 1 || TIMEOUT_TICKS == '0) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_wr_d    = 1'b0;
        cmd_rd_d    = 1'b0;
        cmd_error_d = 1'b0;
        acc_cnt_d   = acc_cnt_q;

        if (rx_valid && rx_data != CH_CR) begin
            case (state_q)
                IDLE: begin
                    if (is_cmd_w || is_cmd_r) begin
                        is_write_d = is_cmd_w;
                        state_d    = ADDR_HI;
                    end else if (rx_data != CH_LF) begin
                        cmd_error_d = 1'b1;
                        state_d     = DRAIN;
                    end
                end
                ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
                    if (hex_ok) begin
                        case (state_q)
                            ADDR_HI: begin
                                addr_sh_d[7:4] = hex_nib;
                                state_d        = ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr_sh_d[3:0] = hex_nib;
                                state_d        = is_write_q ? DATA_HI : TERM;
                            end
                            DATA_HI: begin
                                data_sh_d[7:4] = hex_nib;
                                state_d        = DATA_LO;
                            end
                            default: begin
                                data_sh_d[3:0] = hex_nib;
                                state_d        = TERM;
                            end
                        endcase
                    end else begin
                        cmd_error_d = 1'b1;
                        state_d     = (rx_data == CH_LF) ? IDLE : DRAIN;
                    end
                end
                TERM: begin
                    if (rx_data == CH_LF) begin
                        cmd_addr_d = addr_sh_q;
                        if (is_write_q) begin
                            cmd_data_d = data_sh_q;
                            cmd_wr_d   = 1'b1;
                        end else begin
                            cmd_rd_d   = 1'b1;
                        end
                        acc_cnt_d = acc_cnt_q + 4'd1;
                        state_d   = IDLE;
                    end else begin
                        cmd_error_d = 1'b1;
                        state_d     = DRAIN;
                    end
                end
                default: begin
                    if (rx_data == CH_LF) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end else if (tmo_fire) begin
            cmd_error_d = 1'b1;
            state_d     = IDLE;
        end

        err_cnt_d = err_cnt_q;
        if (cmd_error_d && err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            addr_sh_q   <= 8'd0;
            data_sh_q   <= 8'd0;
            cmd_addr_q  <= 8'd0;
            cmd_data_q  <= 8'd0;
            cmd_wr_q    <= 1'b0;
            cmd_rd_q    <= 1'b0;
            cmd_error_q <= 1'b0;
            acc_cnt_q   <= 4'd0;
            err_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_error_q <= cmd_error_d;
            acc_cnt_q   <= acc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_wr    = cmd_wr_q;
    assign cmd_rd    = cmd_rd_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_error = cmd_error_q;
    assign status    = {err_cnt_q, acc_cnt_q};
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Bench for debug_cmd_decoder: directed command lines plus randomized byte streams,
// checked every cycle against a line-buffer model of the command grammar.
module tb_debug_cmd_decoder;

    localparam int         TICKS = 100;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_wr, cmd_rd, cmd_error, busy;
    logic [7:0] cmd_addr, cmd_data, status;

    always #5 clk_in = ~clk_in;

    debug_cmd_decoder #(
        .TIMEOUT_TICKS_WIDTH(24),
        .TIMEOUT_TICKS      (24'd100)
    ) dut (
        .clk_in   (clk_in),
        .reset    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd_wr   (cmd_wr),
        .cmd_rd   (cmd_rd),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_error(cmd_error),
        .status   (status),
        .busy     (busy)
    );

    // Model: the bytes of the current line, a drain flag and idle-gap length.
    logic [7:0] line_q[$];
    bit         m_drain;
    int         m_gap;
    bit         m_wr, m_rd, m_err;
    logic [7:0] m_addr, m_data;
    int         m_acc, m_errc;
    bit         cmp_en;

    int n_vec;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic logic [3:0] hexval(input logic [7:0] b);
        int v;
        if (b >= "0" && b <= "9")      v = int'(b) - 48;
        else if (b >= "A" && b <= "F") v = int'(b) - 55;
        else                           v = int'(b) - 87;
        return v[3:0];
    endfunction

    function automatic bit m_busy();
        return (line_q.size() > 0) || m_drain;
    endfunction

    task automatic model_reset();
        line_q.delete();
        m_drain = 0; m_gap = 0;
        m_wr = 0; m_rd = 0; m_err = 0;
        m_addr = 0; m_data = 0; m_acc = 0; m_errc = 0;
    endtask

    task automatic model_error(input bit drain);
        m_err = 1;
        if (m_errc < 15) m_errc++;
        line_q.delete();
        m_drain = drain;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int  i, len;
        bit  wr_cmd;
        m_gap = 0;
        if (b == CR) return;
        if (m_drain) begin
            if (b == LF) m_drain = 0;
            return;
        end
        line_q.push_back(b);
        i = line_q.size() - 1;
        if (i == 0) begin
            if (b == LF) line_q.delete();
            else if (!(b == "W" || b == "w" || b == "R" || b == "r")) model_error(1);
            return;
        end
        wr_cmd = (line_q[0] == "W" || line_q[0] == "w");
        len = wr_cmd ? 6 : 4;
        if (i < len - 1) begin
            if (!is_hex(b)) model_error(b != LF);
        end else if (b == LF) begin
            m_addr = {hexval(line_q[1]), hexval(line_q[2])};
            if (wr_cmd) begin
                m_data = {hexval(line_q[3]), hexval(line_q[4])};
                m_wr = 1;
            end else begin
                m_rd = 1;
            end
            m_acc = (m_acc + 1) % 16;
            line_q.delete();
        end else begin
            model_error(1);
        end
    endtask

    task automatic model_idle();
`ifdef DEBUG_CMD_TIMEOUT_EN
        if (!m_busy()) m_gap = 0;
        else if (m_gap == TICKS) model_error(0);
        else m_gap++;
`endif
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        @(posedge clk_in);
        m_wr = 0; m_rd = 0; m_err = 0;
        if (v) model_byte(b);
        else   model_idle();
        #1;
        rx_valid = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00);
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_wr", {31'd0, cmd_wr}, 32'd0);
        check("rst_rd", {31'd0, cmd_rd}, 32'd0);
        check("rst_err", {31'd0, cmd_error}, 32'd0);
        check("rst_addr", {24'd0, cmd_addr}, 32'd0);
        check("rst_data", {24'd0, cmd_data}, 32'd0);
        check("rst_status", {24'd0, status}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1;
    endtask

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("wr", {31'd0, cmd_wr}, {31'd0, m_wr});
            check("rd", {31'd0, cmd_rd}, {31'd0, m_rd});
            check("err", {31'd0, cmd_error}, {31'd0, m_err});
            check("addr", {24'd0, cmd_addr}, {24'd0, m_addr});
            check("data", {24'd0, cmd_data}, {24'd0, m_data});
            check("status", {24'd0, status}, {24'd0, m_errc[3:0], m_acc[3:0]});
            check("busy", {31'd0, busy}, {31'd0, m_busy()});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         err_seen, err_at;
        string      alph;
        logic [7:0] q[$];
        logic [7:0] b;
        bit         is_w;
        int         k, g;

        n_vec = 0; n_err = 0;
        rx_valid = 0; rx_data = 0; cmp_en = 0;
        model_reset();
        rst_n = 0;
        #12;
        cmp_en = 1;
        pulse_reset();

        send_str("W3A5C\n");
        @(negedge clk_in);
        check("t1_wr", {31'd0, cmd_wr}, 32'd1);
        check("t1_addr", {24'd0, cmd_addr}, 32'h3A);
        check("t1_data", {24'd0, cmd_data}, 32'h5C);
        check("t1_status", {24'd0, status}, 32'h01);
        check("t1_busy", {31'd0, busy}, 32'd0);
        idle(1);
        @(negedge clk_in);
        check("t1_wr_len", {31'd0, cmd_wr}, 32'd0);

        send_str("r7f"); step(1, CR); step(1, LF);
        @(negedge clk_in);
        check("t2_rd", {31'd0, cmd_rd}, 32'd1);
        check("t2_wr", {31'd0, cmd_wr}, 32'd0);
        check("t2_addr", {24'd0, cmd_addr}, 32'h7F);
        check("t2_data", {24'd0, cmd_data}, 32'h5C);
        check("t2_status", {24'd0, status}, 32'h02);

        send_str("W3G");
        @(negedge clk_in);
        check("t3_err", {31'd0, cmd_error}, 32'd1);
        check("t3_status_err", {24'd0, status}, 32'h12);
        send_str("9\n");
        @(negedge clk_in);
        check("t3_drain_busy", {31'd0, busy}, 32'd0);
        send_str("R01\n");
        @(negedge clk_in);
        check("t3_rd", {31'd0, cmd_rd}, 32'd1);
        check("t3_addr", {24'd0, cmd_addr}, 32'h01);
        check("t3_status", {24'd0, status}, 32'h13);

        send_str("W12\n");
        @(negedge clk_in);
        check("t4_err", {31'd0, cmd_error}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        send_str("R00\n");
        @(negedge clk_in);
        check("t4_rd", {31'd0, cmd_rd}, 32'd1);
        check("t4_addr", {24'd0, cmd_addr}, 32'h00);
        check("t4_status", {24'd0, status}, 32'h24);

        send_str("W1");
        err_seen = 0; err_at = -1;
        for (int j = 1; j <= 110; j++) begin
            step(0, 8'h00);
            @(negedge clk_in);
            if (cmd_error === 1'b1) begin
                err_seen++;
                if (err_at < 0) err_at = j;
            end
        end
`ifdef DEBUG_CMD_TIMEOUT_EN
        check("t5_err_count", err_seen, 32'd1);
        check("t5_err_cycle", err_at, 32'd101);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_status", {24'd0, status}, 32'h34);
        send_str("\n");
`else
        check("t5_err_count", err_seen, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        check("t5_status", {24'd0, status}, 32'h24);
        send_str("\n");
        @(negedge clk_in);
        check("t5_status_lf", {24'd0, status}, 32'h34);
`endif

        send_str("W12");
        pulse_reset();
        send_str("W0001\n");
        @(negedge clk_in);
        check("t6_wr", {31'd0, cmd_wr}, 32'd1);
        check("t6_addr", {24'd0, cmd_addr}, 32'h00);
        check("t6_data", {24'd0, cmd_data}, 32'h01);
        check("t6_status", {24'd0, status}, 32'h01);

        alph = "0123456789abcdefABCDEFWwRrGz x\n";
        for (int n = 0; n < 700; n++) begin
            q.delete();
            k = $urandom_range(0, 99);
            if (k < 8) begin
                q.push_back(alph[$urandom_range(0, alph.len() - 1)]);
            end else begin
                is_w = $urandom_range(0, 1);
                q.push_back(is_w ? ($urandom_range(0, 1) ? "W" : "w") : ($urandom_range(0, 1) ? "R" : "r"));
                for (int d = 0; d < (is_w ? 4 : 2); d++) q.push_back(alph[$urandom_range(0, 21)]);
                if ($urandom_range(0, 9) == 0) q.push_back(CR);
                q.push_back(LF);
                if ($urandom_range(0, 99) < 15) q[$urandom_range(0, q.size() - 1)] = alph[$urandom_range(0, alph.len() - 1)];
            end
            foreach (q[i]) begin
                b = q[i];
                if ($urandom_range(0, 15) == 0) step(1, CR);
                step(1, b);
                g = $urandom_range(0, 99);
                if (g >= 97)      idle(TICKS + 5);
                else if (g >= 70) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_cmd_decoder.md
# debug_cmd_decoder

Receive-side command decoder for the debug serial channel. It consumes the byte stream from the debug UART receiver (its received byte plus the one-cycle received-data pulse) and parses short ASCII-hex command lines into register write/read requests. It exposes a status byte that the periodic debug transmitter can sample and echo back to the host.

## Interface

Parameters:
- TIMEOUT_TICKS_WIDTH, 24, width of the inter-byte timeout counter.
- TIMEOUT_TICKS, 24'd2200000, idle clocks allowed between bytes of one command (~100 ms at 22 MHz).

Ports:
- clk_in  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte, valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- cmd_wr  output  1  one-cycle write-request pulse.
- cmd_rd  output  1  one-cycle read-request pulse.
- cmd_addr  output  8  register address of the last committed command; held between commands.
- cmd_data  output  8  write data of the last committed write; held between commands.
- cmd_error  output  1  one-cycle pulse per rejected or aborted command.
- status  output  8  {error_count[3:0], accept_count[3:0]}.
- busy  output  1  high whenever state != IDLE.

## Operation

- Grammar, one command per line:
  - Write: 'W'|'w', hex addr (2 digits), hex data (2 digits), 0x0A.
  - Read: 'R'|'r', hex addr (2 digits), 0x0A.
  - Hex digits are '0'-'9', 'A'-'F' and 'a'-'f', most significant nibble first.
- 0x0D (CR) is discarded in every state with no state change. It does reset the timeout.
- States and transitions:
  - IDLE: on 'W'/'R' go to ADDR_HI. On 0x0A stay (empty line, no error). Any other byte: error, go to DRAIN.
  - ADDR_HI: hex digit goes to ADDR_LO.
  - ADDR_LO: hex digit goes to DATA_HI for a write, TERM for a read.
  - DATA_HI: hex digit goes to DATA_LO.
  - DATA_LO: hex digit goes to TERM.
  - In ADDR_HI, ADDR_LO, DATA_HI and DATA_LO: 0x0A means error, go to IDLE. Any other non-hex byte means error, go to DRAIN.
  - TERM: 0x0A commits the command and goes to IDLE. Any other byte: error, go to DRAIN.
  - DRAIN: discard bytes until 0x0A, then go to IDLE. No further error pulses while draining.
- Addr and data nibbles go into shadow registers. cmd_addr and cmd_data update only on commit.
- A read commit updates cmd_addr only; cmd_data keeps its value.
- accept_count increments mod 16 on every commit.
- error_count increments on every cmd_error and saturates at 4'hF.
- cmd_wr, cmd_rd and cmd_error are mutually exclusive in any cycle.

## Timing

- Reset values: cmd_wr=0, cmd_rd=0, cmd_addr=0, cmd_data=0, cmd_error=0, status=0, busy=0, state=IDLE, shadow registers=0, timeout counter=0.
- Latency: cmd_wr or cmd_rd rises on the clock edge after the edge that samples the terminating rx_valid. It lasts exactly one cycle. cmd_addr and cmd_data are valid in that same cycle.
- cmd_error rises one cycle after the offending byte is sampled and lasts one cycle. status reflects the updated counts in the same cycle as the pulse.
- Back-to-back rx_valid is fully supported; no byte is dropped. A new command may start on the cycle after a commit.
- Reset asserted mid-command: everything returns to reset values immediately, with no pulse. Decoding restarts in IDLE after release.
- Timeout (macro enabled):
  - The counter clears in IDLE and on every rx_valid, and increments otherwise.
  - When it equals TIMEOUT_TICKS while state != IDLE: cmd_error pulses, the counter clears, and state goes to IDLE. This applies to DRAIN too.
  - If rx_valid coincides with the timeout cycle, the byte is processed and no timeout occurs.

## Configuration

- DEBUG_CMD_TIMEOUT_EN defined: the inter-byte timeout counter and abort path are compiled in, as described above.
- Undefined: no counter logic exists. A partial command waits indefinitely, and TIMEOUT_TICKS and TIMEOUT_TICKS_WIDTH are unused.

## Test plan

- Write: send "W3A5C\n" → cmd_wr high for 1 cycle, one cycle after the '\n' strobe, with cmd_addr=0x3A, cmd_data=0x5C. status=0x01, busy low afterwards.
- Read with CR: then send "r7f\r\n" → cmd_rd for 1 cycle with cmd_addr=0x7F. cmd_data stays 0x5C, status=0x02, and cmd_wr never asserts.
- Bad digit plus drain: send "W3G9\n" then "R01\n" → cmd_error once, one cycle after 'G'. No pulse for '9' or the first '\n'. status=0x13 after the read commits, with cmd_addr=0x01.
- Early newline: send "W12\n" → cmd_error one cycle after '\n', state IDLE. A following "R00\n" produces cmd_rd with cmd_addr=0x00.
- Timeout (macro defined, TIMEOUT_TICKS=100): send "W1", then idle 110 cycles → exactly one cmd_error, about 100 cycles after '1'. busy drops at the same time and error_count increments. With the macro undefined, busy stays high and there is no error.
- Reset mid-command: send "W12", then pulse reset low → all outputs 0. Then send "W0001\n" → cmd_wr with addr 0x00, data 0x01, status=0x01.
